// File: rtl/wt_fir_mc.sv
// Multi-channel decimating FIR: per-channel delay lines, one serial MAC tap per enabled clock.
// Define WT_FIR_SAT_EN to saturate odat (and flag osat) instead of wrapping.
module wt_fir_mc #(
   parameter int unsigned pWIDTH    = 12,
   parameter int unsigned pCWIDTH   = 13,
   parameter int unsigned pORDER    = 12,
   parameter int unsigned pCHANNELS = 1,
   parameter int unsigned pDECIM    = 1,
   parameter int          cCOEFS [pORDER] =
      '{-5, 19, 2, -130, 112, 399, -532, -927, 1291, 3076, 2025, 456},
   localparam int unsigned CW = (pCHANNELS > 1) ? $clog2(pCHANNELS) : 1
) (
   input  logic                        iclk,
   input  logic                        irst,
   input  logic                        iclk_ena,
   input  logic                        iena,
   input  logic [CW-1:0]               ichan,
   input  logic signed [pWIDTH-1:0]    idat,
   output logic                        ordy,
   output logic                        oena,
   output logic [CW-1:0]               ochan,
   output logic signed [2*pWIDTH-1:0]  odat,
   output logic                        osat
);

   localparam int unsigned AW = pWIDTH + pCWIDTH + $clog2(pORDER);
   localparam int unsigned OW = 2 * pWIDTH;
   localparam int unsigned KW = $clog2(pORDER);
   localparam int unsigned PW = (pDECIM > 1) ? $clog2(pDECIM) : 1;
   localparam logic [KW-1:0] KLAST = KW'(pORDER - 1);
   localparam logic [PW-1:0] PLAST = PW'(pDECIM - 1);

   typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

   state_e                     state;
   logic signed [pWIDTH-1:0]   taps [pCHANNELS][pORDER];
   logic [PW-1:0]              phase [pCHANNELS];
   logic signed [AW-1:0]       acc;
   logic [KW-1:0]              k;
   logic [CW-1:0]              chan;

   logic                              chan_ok;
   logic signed [pCWIDTH-1:0]         coef_k;
   logic signed [pWIDTH-1:0]          tap_k;
   logic signed [pCWIDTH+pWIDTH-1:0]  prod;
   logic signed [OW-1:0]              odat_nxt;
   logic                              osat_nxt;

   always_comb begin
      chan_ok = 32'(ichan) < pCHANNELS;
      coef_k  = pCWIDTH'(cCOEFS[k]);
      tap_k   = taps[chan][k];
      prod    = coef_k * tap_k;
   end

   // Output formatting: plain wrap by default, clip to the odat range when saturation is built in.
   always_comb begin
      odat_nxt = OW'(acc);
      osat_nxt = 1'b0;
`ifdef WT_FIR_SAT_EN
      if (AW'(odat_nxt) != acc) begin
         odat_nxt = acc[AW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
         osat_nxt = 1'b1;
      end
`endif
   end

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         for (int c = 0; c < pCHANNELS; c++) begin
            for (int t = 0; t < pORDER; t++) taps[c][t] <= '0;
            phase[c] <= '0;
         end
         state <= StIdle;
         acc   <= '0;
         k     <= '0;
         chan  <= '0;
         ordy  <= 1'b1;
         oena  <= 1'b0;
         ochan <= '0;
         odat  <= '0;
         osat  <= 1'b0;
      end else begin
         // oena is a single-iclk pulse, independent of the clock enable
         oena <= 1'b0;
         if (iclk_ena) begin
            case (state)
               StIdle: begin
                  if (iena && chan_ok) begin
                     for (int t = pORDER - 1; t > 0; t--) taps[ichan][t] <= taps[ichan][t-1];
                     taps[ichan][0] <= idat;
                     if (phase[ichan] == PLAST) begin
                        phase[ichan] <= '0;
                        acc          <= '0;
                        k            <= '0;
                        chan         <= ichan;
                        ordy         <= 1'b0;
                        state        <= StMac;
                     end else begin
                        phase[ichan] <= phase[ichan] + PW'(1);
                     end
                  end
               end
               StMac: begin
                  acc <= acc + AW'(prod);
                  k   <= k + KW'(1);
                  if (k == KLAST) state <= StDone;
               end
               StDone: begin
                  odat  <= odat_nxt;
                  osat  <= osat_nxt;
                  ochan <= chan;
                  oena  <= 1'b1;
                  ordy  <= 1'b1;
                  state <= StIdle;
               end
               default: begin
                  ordy  <= 1'b1;
                  state <= StIdle;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/wt_fir_mc.md
# wt_fir_mc

Multi-channel, decimating successor to the wavelet-core FIR filter. It keeps a separate delay line and decimation phase for each of pCHANNELS time-multiplexed channels, and evaluates each output with one serial multiply-accumulate, one tap per enabled clock. It sits between the sample source and the wavelet analysis stages. Because of the optional decimation, a single instance can serve as a wavelet low-pass or high-pass branch for several channels.

## Interface
- pWIDTH, 12: signed input sample width.
- pCWIDTH, 13: signed coefficient width.
- pORDER, 12: number of taps, ≥2.
- pCHANNELS, 1: independent channels, ≥1.
- pDECIM, 1: decimation factor, ≥1.
- cCOEFS, '{-5,19,2,-130,112,399,-532,-927,1291,3076,2025,456}: int array[pORDER]; cCOEFS[0] weights the newest sample.
- iclk in 1: single clock.
- irst in 1: reset, asynchronous, active-high.
- iclk_ena in 1: clock enable; all state advances only on iclk edges with iclk_ena=1, except that oena clears unconditionally.
- iena in 1: input sample valid.
- ichan in max(1,$clog2(pCHANNELS)): channel of idat.
- idat in pWIDTH: signed sample.
- ordy out 1: ready to accept.
- oena out 1: output valid, one-iclk pulse.
- ochan out max(1,$clog2(pCHANNELS)): channel of odat.
- odat out 2*pWIDTH: signed filter output.
- osat out 1: odat was saturated; only meaningful with WT_FIR_SAT_EN.

## Operation
- Per channel state:
  - delay line tap[0..pORDER-1] of pWIDTH, where tap[0] is the newest sample;
  - phase counter 0..pDECIM-1.
- Accept condition: iclk_ena & iena & ordy. Sample handling on accept:
  - idat shifts into tap[0] of channel ichan; the other channels are untouched.
  - ichan ≥ pCHANNELS: the sample is discarded and no state changes.
- Decimation on accept:
  - phase ≠ pDECIM-1: phase increments, no computation is started, and the FSM stays in IDLE.
  - phase = pDECIM-1: phase returns to 0 and the FSM starts a computation on that channel, using the updated delay line.
  - Result: y[n] = Σ cCOEFS[k]·x[n-k] for each n where (n mod pDECIM) = pDECIM-1, with n counted from reset per channel.
- Accumulator: signed, pWIDTH+pCWIDTH+$clog2(pORDER) bits, full precision, with no intermediate rounding.
- FSM states:
  - IDLE: ordy=1.
  - MAC: ordy=0; k runs 0..pORDER-1; each enabled cycle does acc += cCOEFS[k]·tap[k]; leaves for DONE after k=pORDER-1.
  - DONE: ordy=0; the next enabled cycle registers odat, osat and ochan, pulses oena, and returns to IDLE.
- Accept in IDLE loads acc=0, k=0 and latches the channel number.
- iena while ordy=0 is ignored. The sample is lost; the upstream side must respect ordy.
- A sample with pDECIM>1 and no computation due is accepted in IDLE without leaving IDLE, so back-to-back acceptance is possible.
- Output width: odat takes the low 2*pWIDTH bits of acc, with two's-complement wrap, unless WT_FIR_SAT_EN is defined.

## Timing
- Accept edge E0; MAC edges are the next pORDER enabled edges; the DONE edge is enabled edge pORDER+1.
- oena is high for exactly the one iclk cycle after the DONE edge. It clears on the next iclk edge regardless of iclk_ena.
- odat and ochan hold their values until the next DONE.
- Latency from accept to oena is pORDER+1 enabled cycles. Throughput is one computed output per pORDER+2 enabled cycles.
- ordy falls after E0 and rises after the DONE edge, so a new accept is possible on the next enabled edge.
- Reset values: all delay lines and phases 0, FSM IDLE, acc 0, ordy 1, oena 0, odat 0, ochan 0, osat 0.
- irst asserted mid-MAC or mid-DONE aborts immediately: no oena is produced, and all state returns to its reset values asynchronously.
- iclk_ena low during MAC freezes k and acc; the result is unchanged.

## Configuration
- WT_FIR_SAT_EN defined:
  - odat saturates the accumulator to [-2^(2*pWIDTH-1), 2^(2*pWIDTH-1)-1];
  - osat=1 with that oena when the value was clipped, otherwise 0.
- WT_FIR_SAT_EN undefined:
  - odat wraps (truncation of the upper bits);
  - osat is constant 0.

## Test plan
- Impulse, defaults (pDECIM=1, 1 channel): idat=1, then 11 zeros → odat sequence -5,19,2,-130,112,399,-532,-927,1291,3076,2025,456, each oena 13 enabled cycles after its accept.
- Decimation, pDECIM=2: same impulse plus 11 zeros → exactly 6 outputs: 19,-130,399,-927,3076,456.
- Channels, pCHANNELS=2: impulse 1 on ch0 interleaved with constant 100 on ch1 → ch0 gives the coefficient sequence; ch1 settles at 578600 (100·5786); ochan matches each result.
- Overflow: constant -2048 for 12 samples → the 12th output is -8388608 with osat=1 when WT_FIR_SAT_EN is defined, and 4927488 with osat=0 when it is undefined.
- Handshake/enable: iena held high while ordy=0 → samples dropped, outputs identical to a clean stream. iclk_ena toggling 1-in-16 → identical odat values, with latency scaled.
- Reset mid-MAC: irst pulse during k=5 → no oena; outputs at reset values; the next impulse reproduces the first scenario exactly.
